// File: rtl/seq_alu.sv
// seq_alu: registered W-bit ALU, start/done handshake, optional shift-add mul.
// Ports: ck, rst_n (async low), start, op[2:0], in1/in2[W-1:0] ->
//   out1[W-1:0], zero, carry, ovf, err, busy, done. Macro: SEQ_ALU_MUL_EN.
module seq_alu #(
  parameter int W  = 8,
  parameter int CW = $clog2(W) + 1
) (
  input  logic         ck,
  input  logic         rst_n,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [W-1:0] in1,
  input  logic [W-1:0] in2,
  output logic [W-1:0] out1,
  output logic         zero,
  output logic         carry,
  output logic         ovf,
  output logic         err,
  output logic         busy,
  output logic         done
);

  if (W < 2 || (1 << CW) < W) begin : g_bad_param
    $error("seq_alu: illegal W/CW");
  end

  logic [W:0]   sum;
  logic [W:0]   dif;
  logic [W-1:0] res;
  logic         res_c;
  logic         res_v;
  logic         res_e;
  logic         lt;

  assign sum = {1'b0, in1} + {1'b0, in2};
  assign dif = {1'b0, in1} - {1'b0, in2};
  assign lt  = $signed(in1) < $signed(in2);

  always_comb begin
    res   = '0;
    res_c = 1'b0;
    res_v = 1'b0;
    res_e = 1'b0;
    unique case (op)
      3'b000: begin
        res   = sum[W-1:0];
        res_c = sum[W];
        res_v = (in1[W-1] == in2[W-1]) &&
                (sum[W-1] != in1[W-1]);
      end
      3'b001: begin
        res   = dif[W-1:0];
        res_c = dif[W];
        res_v = (in1[W-1] != in2[W-1]) &&
                (dif[W-1] != in1[W-1]);
      end
      3'b010: res = in1 & in2;
      3'b011: res = in1 | in2;
      3'b100: res = in1 ^ in2;
      3'b101: res = W'(lt);
      3'b110: begin
`ifdef SEQ_ALU_MUL_EN
        res_e = 1'b0;
`else
        res_e = 1'b1;
`endif
      end
      3'b111: res = in2;
    endcase
  end

  logic [W-1:0] out1_n;
  logic         zero_n;
  logic         carry_n;
  logic         ovf_n;
  logic         err_n;
  logic         done_n;
  logic         ld;

`ifdef SEQ_ALU_MUL_EN
  typedef enum logic {IDLE = 1'b0, MUL = 1'b1} state_t;

  state_t         state, state_n;
  logic [2*W-1:0] acc, acc_n, acc_add;
  logic [2*W-1:0] mcand, mcand_n;
  logic [W-1:0]   mplier, mplier_n;
  logic [CW-1:0]  cnt, cnt_n;

  assign busy    = (state == MUL);
  assign acc_add = acc + (mplier[0] ? mcand : '0);
`else
  assign busy = 1'b0;
`endif

  always_comb begin
    out1_n  = out1;
    zero_n  = zero;
    carry_n = carry;
    ovf_n   = ovf;
    err_n   = err;
    done_n  = 1'b0;
    ld      = 1'b0;
`ifdef SEQ_ALU_MUL_EN
    state_n  = state;
    acc_n    = acc;
    mcand_n  = mcand;
    mplier_n = mplier;
    cnt_n    = cnt;
    unique case (state)
      IDLE: begin
        if (start && op == 3'b110) begin
          state_n  = MUL;
          acc_n    = '0;
          cnt_n    = '0;
          mcand_n  = {{W{1'b0}}, in1};
          mplier_n = in2;
        end else if (start) begin
          ld = 1'b1;
        end
      end
      MUL: begin
        acc_n    = acc_add;
        mcand_n  = mcand << 1;
        mplier_n = mplier >> 1;
        cnt_n    = cnt + 1'b1;
        // last iteration: fold final partial product straight into out1
        if (cnt == CW'(W - 1)) begin
          state_n = IDLE;
          cnt_n   = '0;
          out1_n  = acc_add[W-1:0];
          zero_n  = (acc_add[W-1:0] == '0);
          carry_n = |acc_add[2*W-1:W];
          ovf_n   = 1'b0;
          err_n   = 1'b0;
          done_n  = 1'b1;
        end
      end
    endcase
`else
    ld = start;
`endif
    if (ld) begin
      out1_n  = res;
      zero_n  = (res == '0);
      carry_n = res_c;
      ovf_n   = res_v;
      err_n   = res_e;
      done_n  = 1'b1;
    end
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      out1  <= '0;
      zero  <= 1'b0;
      carry <= 1'b0;
      ovf   <= 1'b0;
      err   <= 1'b0;
      done  <= 1'b0;
    end else begin
      out1  <= out1_n;
      zero  <= zero_n;
      carry <= carry_n;
      ovf   <= ovf_n;
      err   <= err_n;
      done  <= done_n;
    end
  end

`ifdef SEQ_ALU_MUL_EN
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else begin
      state  <= state_n;
      acc    <= acc_n;
      mcand  <= mcand_n;
      mplier <= mplier_n;
      cnt    <= cnt_n;
    end
  end
`endif

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed-vector bench for seq_alu at W=8.
// Covers both builds of SEQ_ALU_MUL_EN.
module tb_seq_alu;

  logic       ck = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [2:0] op = 3'b000;
  logic [7:0] in1 = '0;
  logic [7:0] in2 = '0;
  logic [7:0] out1;
  logic       zero, carry, ovf, err, busy, done;

  int nchk = 0;
  int nerr = 0;

  seq_alu #(.W(8)) dut (
    .ck(ck), .rst_n(rst_n), .start(start), .op(op),
    .in1(in1), .in2(in2), .out1(out1), .zero(zero),
    .carry(carry), .ovf(ovf), .err(err), .busy(busy),
    .done(done)
  );

  always #5 ck = ~ck;

  task automatic chk(input string tag,
                     input logic [15:0] got,
                     input logic [15:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_op(input logic [2:0] o,
                       input logic [7:0] a,
                       input logic [7:0] b);
    @(negedge ck);
    start = 1'b1;
    op    = o;
    in1   = a;
    in2   = b;
    @(posedge ck);
    #1;
    start = 1'b0;
  endtask

  task automatic expect_res(input string tag,
                            input logic [7:0] r,
                            input logic c,
                            input logic v,
                            input logic z,
                            input logic e);
    chk({tag, ".out1"}, 16'(out1), 16'(r));
    chk({tag, ".carry"}, 16'(carry), 16'(c));
    chk({tag, ".ovf"}, 16'(ovf), 16'(v));
    chk({tag, ".zero"}, 16'(zero), 16'(z));
    chk({tag, ".err"}, 16'(err), 16'(e));
    chk({tag, ".done"}, 16'(done), 16'd1);
  endtask

  initial begin
    int nd;
    #1;
    chk("rst.out1", 16'(out1), 16'd0);
    chk("rst.flags", 16'({zero, carry, ovf, err}), 16'd0);
    chk("rst.busy", 16'(busy), 16'd0);
    chk("rst.done", 16'(done), 16'd0);
    @(negedge ck);
    rst_n = 1'b1;

    do_op(3'b000, 8'd200, 8'd100);
    expect_res("add200+100", 8'd44, 1, 0, 0, 0);
    @(posedge ck); #1;
    chk("done_fall", 16'(done), 16'd0);
    chk("hold_out1", 16'(out1), 16'd44);

    do_op(3'b000, 8'd127, 8'd1);
    expect_res("add127+1", 8'd128, 0, 1, 0, 0);
    do_op(3'b001, 8'd5, 8'd7);
    expect_res("sub5-7", 8'd254, 1, 0, 0, 0);
    do_op(3'b101, 8'd253, 8'd2);
    expect_res("slt-3<2", 8'd1, 0, 0, 0, 0);
    do_op(3'b101, 8'd2, 8'd253);
    expect_res("slt2<-3", 8'd0, 0, 0, 1, 0);
    do_op(3'b010, 8'hF0, 8'h3C);
    expect_res("and", 8'h30, 0, 0, 0, 0);
    do_op(3'b011, 8'hF0, 8'h0F);
    expect_res("or", 8'hFF, 0, 0, 0, 0);
    do_op(3'b100, 8'hAA, 8'hAA);
    expect_res("xor", 8'h00, 0, 0, 1, 0);
    do_op(3'b111, 8'h11, 8'h5A);
    expect_res("pass", 8'h5A, 0, 0, 0, 0);
    do_op(3'b001, 8'h80, 8'h01);
    expect_res("sub80-1", 8'h7F, 0, 1, 0, 0);
    do_op(3'b000, 8'hFF, 8'h01);
    expect_res("addFF+1", 8'h00, 1, 0, 1, 0);

`ifdef SEQ_ALU_MUL_EN
    do_op(3'b110, 8'd13, 8'd11);
    chk("mul.busy_k", 16'(busy), 16'd1);
    nd = 0;
    for (int j = 1; j <= 7; j++) begin
      @(negedge ck);
      start = 1'b1;
      op    = 3'b000;
      in1   = 8'(j * 37);
      in2   = 8'd3;
      @(posedge ck); #1;
      chk($sformatf("mul.busy_k%0d", j), 16'(busy), 16'd1);
      if (done) nd++;
    end
    @(posedge ck); #1;
    start = 1'b0;
    expect_res("mul13x11", 8'd143, 0, 0, 0, 0);
    chk("mul.busy_end", 16'(busy), 16'd0);
    nd++;
    for (int j = 0; j < 2; j++) begin
      @(posedge ck); #1;
      if (done) nd++;
    end
    chk("mul.ndone", 16'(nd), 16'd1);
    chk("mul.hold", 16'(out1), 16'd143);

    do_op(3'b110, 8'd20, 8'd20);
    repeat (8) @(posedge ck);
    #1;
    expect_res("mul20x20", 8'd144, 1, 0, 0, 0);

    do_op(3'b110, 8'd13, 8'd11);
    repeat (4) @(posedge ck);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort.out1", 16'(out1), 16'd0);
    chk("abort.flags", 16'({zero, carry, ovf, err}), 16'd0);
    chk("abort.busy", 16'(busy), 16'd0);
    chk("abort.done", 16'(done), 16'd0);
    @(negedge ck);
    rst_n = 1'b1;
    nd = 0;
    repeat (10) begin
      @(posedge ck); #1;
      if (done || busy) nd++;
    end
    chk("abort.quiet", 16'(nd), 16'd0);
    do_op(3'b000, 8'd1, 8'd1);
    expect_res("post_abort", 8'd2, 0, 0, 0, 0);
`else
    do_op(3'b110, 8'd13, 8'd11);
    expect_res("mul_off", 8'd0, 0, 0, 1, 1);
    chk("mul_off.busy", 16'(busy), 16'd0);
    @(posedge ck); #1;
    chk("mul_off.busy2", 16'(busy), 16'd0);
    chk("mul_off.done_fall", 16'(done), 16'd0);
    do_op(3'b000, 8'd1, 8'd1);
    expect_res("after_err", 8'd2, 0, 0, 0, 0);

    do_op(3'b000, 8'd3, 8'd4);
    @(negedge ck);
    start = 1'b1;
    op    = 3'b001;
    in1   = 8'd3;
    in2   = 8'd4;
    @(posedge ck); #1;
    start = 1'b0;
    expect_res("b2b_sub", 8'd255, 1, 0, 0, 0);
    @(negedge ck);
    rst_n = 1'b0;
    #1;
    chk("rst2.out1", 16'(out1), 16'd0);
    chk("rst2.flags", 16'({zero, carry, ovf, err}), 16'd0);
    @(negedge ck);
    rst_n = 1'b1;
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, registered ALU with a start/done handshake, the next-generation arithmetic unit for the team's single-cycle datapath. It replaces the two-operation combinational ALU: operand width is a parameter, the opcode is widened to eight operations, status flags are produced, and an iterative shift-add multiplier is added. It sits between the register file read ports and the write-back mux, driven by the control unit.

## Interface
- `W`, default 8: operand and result width; legal values are W ≥ 2.
- `CW`, default `$clog2(W)+1`: width of the multiply iteration counter.

- `ck`, input, 1: clock; every register updates on the rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `start`, input, 1: request an operation; sampled only while `busy`=0.
- `op`, input, 3: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt (signed), 110 mul, 111 pass `in2`.
- `in1`, input, W: operand A.
- `in2`, input, W: operand B.
- `out1`, output, W: registered result; holds its value until the next completion.
- `zero`, output, 1: registered; set when `out1`==0.
- `carry`, output, 1: registered carry, borrow, or multiply-overflow flag.
- `ovf`, output, 1: registered signed overflow (add/sub only).
- `err`, output, 1: registered; set when the completed op is unsupported.
- `busy`, output, 1: high while a multiply is in progress.
- `done`, output, 1: single-cycle pulse marking the edge where results update.

## Operation
- FSM states: IDLE and MUL.
  - Reset enters IDLE.
  - IDLE, `start`=1, `op`≠110: compute and register the result, pulse `done`, remain in IDLE.
  - IDLE, `start`=1, `op`=110: latch both operands, clear the accumulator and counter, go to MUL.
  - MUL: each cycle, if the multiplier LSB is 1, add the multiplicand to the 2W-bit accumulator. Then shift the multiplicand left and the multiplier right, and increment the counter.
  - After W iterations: register the product, pulse `done`, return to IDLE.
- Flag rules (all flags update only when `done` is pulsed):
  - add: `carry` = bit W of `in1`+`in2`; `ovf` = signed overflow.
  - sub: `carry` = borrow, i.e. `in1` < `in2` unsigned; `ovf` = signed overflow.
  - mul: `out1` = low W bits of the product; `carry` = 1 if any of the upper W bits is nonzero; `ovf` = 0.
  - slt: `out1` = 1 if `in1` < `in2` signed, else 0.
  - Logic ops and pass: `carry` = `ovf` = 0.
  - `err` = 0 for every supported op.
- `start` while `busy`=1 is ignored; it is neither queued nor allowed to corrupt the latched operands.
- Operand changes during MUL have no effect.
- Reset values: `out1`=0, `zero`=0, `carry`=0, `ovf`=0, `err`=0, `busy`=0, `done`=0, state IDLE, counter 0.
- Asserting `rst_n` in the middle of a multiply aborts it immediately and asynchronously. All outputs take their reset values and no `done` is produced.

## Timing
- Single-cycle ops: `start` sampled at edge k, then `out1`, flags and `done`=1 are valid after edge k. `done` falls after edge k+1 unless another op completes there.
- mul: `start` sampled at edge k, `busy`=1 after edge k, and iterations occur at edges k+1 through k+W. At edge k+W the product is registered, `done`=1 and `busy`=0. Latency is W cycles.
- Back-to-back: a `start` at the edge after completion is accepted, so successive single-cycle ops give one result per cycle.
- Wrap-around: add/sub results are modulo 2^W; the multiply accumulator is 2W bits and never truncates internally.

## Configuration
- `SEQ_ALU_MUL_EN` defined: op 110 is the iterative multiplier described above.
- `SEQ_ALU_MUL_EN` undefined:
  - The multiplier datapath, the counter and the MUL state are removed, and `busy` is tied to 0.
  - op 110 completes in a single cycle with `out1`=0, `zero`=1, `carry`=0, `ovf`=0, `err`=1.

## Test plan
All scenarios use W=8.
- add 200+100, `start` at edge k → after edge k: `out1`=44, `carry`=1, `ovf`=0, `zero`=0, `done`=1 for one cycle.
- add 127+1 → `out1`=128, `ovf`=1, `carry`=0. sub 5−7 → `out1`=254, `carry`=1, `ovf`=0. slt −3 vs 2 → `out1`=1.
- mul 13×11 at edge k → `busy`=1 for edges k through k+7; at edge k+8: `out1`=143, `carry`=0, `done`=1. mul 20×20 → `out1`=144, `carry`=1.
- mul 13×11 with `start`=1, op=add asserted during the busy window and `in1` changed mid-multiply → exactly one `done`, `out1`=143.
- `rst_n` pulled low at edge k+4 of a multiply → all outputs are 0 immediately, no `done` follows, and the next add 1+1 gives `out1`=2.
- Build without `SEQ_ALU_MUL_EN`, op 110 with any operands → after edge k: `err`=1, `out1`=0, `zero`=1, `busy` stays 0.
